// File: rtl/fcmp_pkg.sv
// fcmp_pkg: shared types and ordering helpers for the FP compare/select unit.
//   fcmp_op_t : operation encoding (FEQ, FLT, FLE, FMIN, FMAX; codes 5-7 illegal)
//   fcls_t    : ordering class of an operand (NEG < ZERO < POS)
//   fp_lt/fp_eq : core ordering rules; any exponent==0 value is ZERO,
//                 NaN/Inf are ordered by their raw bits like normal values.
package fcmp_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    FEQ  = 3'd0,
    FLT  = 3'd1,
    FLE  = 3'd2,
    FMIN = 3'd3,
    FMAX = 3'd4
  } fcmp_op_t;

  typedef enum logic [1:0] {
    NEG  = 2'd0,
    ZERO = 2'd1,
    POS  = 2'd2
  } fcls_t;

  // a < b under the core ordering; class order decides first, then magnitude
  // (reversed for negatives). Two ZEROs are never less than each other.
  function automatic logic fp_lt(input fcls_t ca, input logic [31:0] a,
                                 input fcls_t cb, input logic [31:0] b);
    logic r;
    if (ca != cb) begin
      r = (ca < cb);
    end else begin
      case (ca)
        POS:     r = (a[30:0] < b[30:0]);
        NEG:     r = (b[30:0] < a[30:0]);
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic fp_eq(input fcls_t ca, input logic [31:0] a,
                                 input fcls_t cb, input logic [31:0] b);
    return ((ca == ZERO) && (cb == ZERO)) || (a == b);
  endfunction

endpackage

// File: rtl/fp_class.sv
// fp_class: combinational ordering classifier for one IEEE-754 single operand.
//   x   in  32  operand
//   cls out     ZERO if exponent==0, else POS/NEG by sign bit
module fp_class
  import fcmp_pkg::*;
(
  input  logic [31:0] x,
  output fcls_t       cls
);

  always_comb begin
    if (x[30:23] == '0) begin
      cls = ZERO;
    end else if (!x[31]) begin
      cls = POS;
    end else begin
      cls = NEG;
    end
  end

endmodule

// File: rtl/fcmp_unit.sv
// fcmp_unit: two-stage pipelined FP compare/select unit (FEQ/FLT/FLE/FMIN/FMAX).
//   clk, rst (async, active high), flush (kills all in-flight ops)
//   in_valid/in_ready, in_op, in_x1, in_x2, in_tag : issue side
//   out_valid/out_ready, out_data, out_tag,
//   out_to_int (1 = integer regfile), out_illegal   : writeback side
// S1 holds operands, op, tag and operand classes; S2 holds the final result.
// Outputs come straight from S2 registers.
module fcmp_unit
  import fcmp_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_to_int,
  output logic             out_illegal
);

  logic             s1_v;
  logic [OP_W-1:0]  s1_op;
  logic [31:0]      s1_x1;
  logic [31:0]      s1_x2;
  logic [TAG_W-1:0] s1_tag;
  fcls_t            s1_c1;
  fcls_t            s1_c2;
  logic             s2_v;

  fcls_t            c1;
  fcls_t            c2;

  logic             s2_adv;
  logic             load1;

  logic             lt12;
  logic             lt21;
  logic             eq12;
  logic [31:0]      nx_data;
  logic             nx_to_int;
  logic             nx_illegal;

  fp_class u_cls1 (.x(in_x1), .cls(c1));
  fp_class u_cls2 (.x(in_x2), .cls(c2));

  assign s2_adv    = !s2_v || out_ready;
  assign in_ready  = (!s1_v || s2_adv) && !flush;
  assign load1     = in_valid && in_ready;
  assign out_valid = s2_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_op  <= '0;
      s1_x1  <= '0;
      s1_x2  <= '0;
      s1_tag <= '0;
      s1_c1  <= NEG;
      s1_c2  <= NEG;
    end else if (flush) begin
      s1_v <= 1'b0;
    end else if (load1) begin
      s1_v   <= 1'b1;
      s1_op  <= in_op;
      s1_x1  <= in_x1;
      s1_x2  <= in_x2;
      s1_tag <= in_tag;
      s1_c1  <= c1;
      s1_c2  <= c2;
    end else if (s2_adv) begin
      s1_v <= 1'b0;
    end
  end

  // FMIN needs lt(x2,x1), everything else uses lt(x1,x2); ties select x1.
  always_comb begin
    lt12       = fp_lt(s1_c1, s1_x1, s1_c2, s1_x2);
    lt21       = fp_lt(s1_c2, s1_x2, s1_c1, s1_x1);
    eq12       = fp_eq(s1_c1, s1_x1, s1_c2, s1_x2);
    nx_data    = '0;
    nx_to_int  = 1'b1;
    nx_illegal = 1'b0;
    case (s1_op)
      FEQ:  nx_data = {31'b0, eq12};
      FLT:  nx_data = {31'b0, lt12};
      FLE:  nx_data = {31'b0, lt12 | eq12};
      FMIN: begin
        nx_data   = lt21 ? s1_x2 : s1_x1;
        nx_to_int = 1'b0;
      end
      FMAX: begin
        nx_data   = lt12 ? s1_x2 : s1_x1;
        nx_to_int = 1'b0;
      end
      default: nx_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v        <= 1'b0;
      out_data    <= '0;
      out_tag     <= '0;
      out_to_int  <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      s2_v <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_data    <= nx_data;
        out_tag     <= s1_tag;
        out_to_int  <= nx_to_int;
        out_illegal <= nx_illegal;
      end
    end
  end

endmodule

// File: tb/tb_fcmp_unit.sv
// tb_fcmp_unit: self-checking bench for fcmp_unit. A reference model orders
// operands by a signed integer key (ZERO -> 0, +x -> magnitude, -x -> -magnitude),
// and a scoreboard queue tracks every accepted op until it is written back.
module tb_fcmp_unit;
  import fcmp_pkg::*;

  localparam int unsigned TW = 5;

  typedef struct packed {
    logic [31:0]   d;
    logic [TW-1:0] t;
    logic          ti;
    logic          il;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [31:0]   in_x1;
  logic [31:0]   in_x2;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [TW-1:0] out_tag;
  logic          out_to_int;
  logic          out_illegal;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic saw_full = 1'b0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [TW-1:0] prev_tag;

  fcmp_unit #(.TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_to_int(out_to_int), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  function automatic longint key(input logic [31:0] v);
    longint m;
    m = longint'({33'b0, v[30:0]});
    if (v[30:23] == 8'd0) return 0;
    else if (!v[31]) return m;
    else return -m;
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [TW-1:0] tag);
    exp_t e;
    longint ka, kb;
    ka = key(a);
    kb = key(b);
    e.t = tag; e.ti = 1'b1; e.il = 1'b0; e.d = '0;
    case (op)
      3'd0: e.d = {31'b0, ka == kb};
      3'd1: e.d = {31'b0, ka < kb};
      3'd2: e.d = {31'b0, ka <= kb};
      3'd3: begin e.d = (kb < ka) ? b : a; e.ti = 1'b0; end
      3'd4: begin e.d = (ka < kb) ? b : a; e.ti = 1'b0; end
      default: e.il = 1'b1;
    endcase
    return e;
  endfunction

  // Scoreboard: judge what the next rising edge will do from stable inputs.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall <= 1'b0;
    end else begin
      chk("in_ready", in_ready, !flush && (q.size() < 2 || out_ready));
      if (in_valid && !in_ready && !flush) saw_full <= 1'b1;
      if (q.size() == 2) chk("out_valid_full", out_valid, 1);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          chk("sb_data", out_data, q[0].d);
          chk("sb_tag", out_tag, q[0].t);
          chk("sb_to_int", out_to_int, q[0].ti);
          chk("sb_illegal", out_illegal, q[0].il);
        end
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_tag", out_tag, prev_tag);
      end
      prev_stall <= out_valid && !out_ready && !flush;
      prev_data  <= out_data;
      prev_tag   <= out_tag;
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && in_ready) q.push_back(model(in_op, in_x1, in_x2, in_tag));
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [TW-1:0] tag);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1; in_op = op; in_x1 = a; in_x2 = b; in_tag = tag;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("send_accept", acc, 1);
  endtask

  task automatic one(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [TW-1:0] tag,
                     input logic [31:0] ed, input logic eti, input logic eil);
    int n;
    n = 0;
    out_ready = 1'b1;
    send(op, a, b, tag);
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_data"}, out_data, ed);
    chk({name, "_tag"}, out_tag, tag);
    chk({name, "_to_int"}, out_to_int, eti);
    chk({name, "_illegal"}, out_illegal, eil);
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  bop [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd4, 3'd3};
  logic [31:0] bx1 [8] = '{32'h3F800000, 32'hBF800000, 32'h40000000, 32'hC0000000,
                           32'h00000005, 32'h41200000, 32'hC1200000, 32'h3F000000};
  logic [31:0] bx2 [8] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40400000,
                           32'h80000001, 32'hC1200000, 32'hC0A00000, 32'hBF000000};

  initial begin
    exp_t m;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_x1 = '0; in_x2 = '0; in_tag = '0; out_ready = 1'b1;

    // Model anchors
    m = model(3'd1, 32'hBF800000, 32'hC0000000, 5'd0); chk("model_flt_neg", m.d, 32'd0);
    m = model(3'd1, 32'hC0000000, 32'hBF800000, 5'd0); chk("model_flt_neg_sw", m.d, 32'd1);
    m = model(3'd0, 32'h80000000, 32'h00000001, 5'd0); chk("model_feq_zero", m.d, 32'd1);
    m = model(3'd4, 32'h80000000, 32'h00000000, 5'd0); chk("model_fmax_tie", m.d, 32'h80000000);

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_to_int", out_to_int, 0);
    chk("rst_out_illegal", out_illegal, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);

    one("feq_zero",   3'd0, 32'h80000000, 32'h00000001, 5'd1, 32'd1, 1'b1, 1'b0);
    one("flt_zero_a", 3'd1, 32'h80000000, 32'h00000001, 5'd2, 32'd0, 1'b1, 1'b0);
    one("flt_zero_b", 3'd1, 32'h00000001, 32'h80000000, 5'd3, 32'd0, 1'b1, 1'b0);
    one("fle_zero",   3'd2, 32'h80000000, 32'h00000001, 5'd4, 32'd1, 1'b1, 1'b0);
    one("flt_neg",    3'd1, 32'hBF800000, 32'hC0000000, 5'd5, 32'd0, 1'b1, 1'b0);
    one("flt_neg_sw", 3'd1, 32'hC0000000, 32'hBF800000, 5'd6, 32'd1, 1'b1, 1'b0);
    one("flt_pos",    3'd1, 32'h3F800000, 32'h40000000, 5'd7, 32'd1, 1'b1, 1'b0);
    one("fmin_pos",   3'd3, 32'h3F800000, 32'h40000000, 5'd8, 32'h3F800000, 1'b0, 1'b0);
    one("fmax_negz",  3'd4, 32'hC0000000, 32'h00000000, 5'd9, 32'h00000000, 1'b0, 1'b0);
    one("fmax_pz_nz", 3'd4, 32'h00000000, 32'h80000000, 5'd10, 32'h00000000, 1'b0, 1'b0);
    one("fmax_nz_pz", 3'd4, 32'h80000000, 32'h00000000, 5'd11, 32'h80000000, 1'b0, 1'b0);
    one("illegal",    3'd6, 32'h3F800000, 32'h40000000, 5'h1F, 32'd0, 1'b1, 1'b1);

    // Back-to-back stream with a three-cycle writeback stall
    fork
      begin
        for (int i = 0; i < 8; i++) send(bop[i], bx1[i], bx2[i], 5'(i + 16));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("stream_saw_full", saw_full, 1);
    chk("stream_drained", q.size(), 0);

    // Flush with both stages full and a new op offered
    out_ready = 1'b0;
    send(3'd1, 32'h3F800000, 32'h40000000, 5'd12);
    send(3'd4, 32'h3F800000, 32'h40000000, 5'd13);
    in_valid = 1'b1; in_op = 3'd0; in_x1 = 32'h1; in_x2 = 32'h1; in_tag = 5'd14;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    repeat (3) @(negedge clk);
    chk("flush_no_output", out_valid, 0);
    chk("flush_queue_empty", q.size(), 0);
    @(posedge clk); #1;

    // Asynchronous reset while a result is on the output
    send(3'd4, 32'h40400000, 32'h40000000, 5'd21);
    send(3'd3, 32'h40400000, 32'h40000000, 5'd22);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_tag", out_tag, 0);
    chk("arst_out_to_int", out_to_int, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);

    one("after_rst", 3'd2, 32'h40000000, 32'h40000000, 5'd23, 32'd1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
